// File: rtl/clk_div_gen.sv
// Purpose : multi-channel programmable clock divider / tick generator with glitch-free divisor reload.
// Latency : enable-to-first-high 1 edge, sync-to-rise 1 edge; all outputs registered.
// Backpressure : none; div_wr_i is a strobe (last write wins), div_pending_o shows an unapplied write.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   ch_en_i[k]        run enable; dropping it lets the current period finish before going idle
//   div_i, div_wr_i   divisor slice k at [k*DIV_W +: DIV_W], captured into a pending register on the strobe
//   sync_i            restarts every running channel at the start of a new period
//   div_pending_o     pending divisor not yet applied
//   clk_div_o, tick_o divided clock (ceil(D/2) high, rest low) and a pulse on the first high cycle
module clk_div_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       div_wr_i,
  input  logic                    sync_i,
  output logic [NUM_CH-1:0]       div_pending_o,
  output logic [NUM_CH-1:0]       clk_div_o,
  output logic [NUM_CH-1:0]       tick_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam logic [DIV_W-1:0] DEF_D = (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);

  // Divisors below 2 cannot produce both a high and a low phase.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    clamp_div = (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q;
    logic             pend_vld_q;
    logic             boundary;
    logic             apply_slot;
    logic             apply;
    logic [DIV_W-1:0] half_d;
    logic             clk_q, tick_q;

    always_comb begin
      boundary   = (cnt_q == div_q - DIV_W'(1));
      state_d    = state_q;
      cnt_d      = cnt_q;
      apply_slot = 1'b0;
      case (state_q)
        ST_IDLE: begin
          // An idle channel has no period to protect, so a pending divisor lands immediately.
          apply_slot = 1'b1;
          cnt_d      = '0;
          if (ch_en_i[k]) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (sync_i) begin
            apply_slot = 1'b1;
            cnt_d      = '0;
            state_d    = ch_en_i[k] ? ST_RUN : ST_STOP;
          end else if (boundary) begin
            // Enable dropped on the last cycle: the period is already complete.
            apply_slot = 1'b1;
            cnt_d      = '0;
            state_d    = ch_en_i[k] ? ST_RUN : ST_IDLE;
          end else begin
            cnt_d   = cnt_q + DIV_W'(1);
            state_d = ch_en_i[k] ? ST_RUN : ST_STOP;
          end
        end
        ST_STOP: begin
          // Sync is ignored here; the channel finishes its period undisturbed.
          if (boundary) begin
            apply_slot = 1'b1;
            cnt_d      = '0;
            state_d    = ch_en_i[k] ? ST_RUN : ST_IDLE;
          end else begin
            cnt_d   = cnt_q + DIV_W'(1);
            state_d = ch_en_i[k] ? ST_RUN : ST_STOP;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
      // Only the registered flag counts, so a write on a boundary waits one more period.
      apply  = apply_slot && pend_vld_q;
      div_d  = apply ? clamp_div(pend_q) : div_q;
      // ceil(D/2) without forming D+1, which would overflow at D = 2^DIV_W-1.
      half_d = (div_d >> 1) + {{(DIV_W-1){1'b0}}, div_d[0]};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        div_q      <= DEF_D;
        pend_q     <= '0;
        pend_vld_q <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        if (div_wr_i[k]) begin
          pend_q     <= div_i[k*DIV_W +: DIV_W];
          pend_vld_q <= 1'b1;
        end else if (apply) begin
          pend_vld_q <= 1'b0;
        end
        // Outputs are decoded from next-state values so they sit directly on flops.
        clk_q  <= (state_d != ST_IDLE) && (cnt_d < half_d);
        tick_q <= (state_d != ST_IDLE) && (cnt_d == '0);
      end
    end

    assign clk_div_o[k]     = clk_q;
    assign tick_o[k]        = tick_q;
    assign div_pending_o[k] = pend_vld_q;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;

  logic        clk;
  logic        rst;
  logic [1:0]  ch_en;
  logic [31:0] div_in;
  logic [1:0]  div_wr;
  logic        sync;
  logic [1:0]  div_pending_o;
  logic [1:0]  clk_div_o;
  logic [1:0]  tick_o;

  int n_chk;
  int n_fail;

  clk_div_gen #(.NUM_CH(2), .DIV_W(16), .DEFAULT_DIV(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_en_i       (ch_en),
    .div_i         (div_in),
    .div_wr_i      (div_wr),
    .sync_i        (sync),
    .div_pending_o (div_pending_o),
    .clk_div_o     (clk_div_o),
    .tick_o        (tick_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each channel is "on" (producing a waveform) at some position
  // within a period of length d; "stop" means it will go quiet at the period end.
  int         m_pos [2];
  int         m_d   [2];
  int         m_pv  [2];
  bit         m_on  [2];
  bit         m_stop[2];
  bit         m_pf  [2];
  bit         m_bnd, m_ap, m_en;
  logic [1:0] e_clk  = 2'b00;
  logic [1:0] e_tick = 2'b00;
  logic [1:0] e_pend = 2'b00;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_on[k] = 0; m_stop[k] = 0; m_pos[k] = 0; m_d[k] = 6; m_pf[k] = 0; m_pv[k] = 0;
      end else begin
        m_en  = ch_en[k];
        m_bnd = m_on[k] && (m_pos[k] == m_d[k] - 1);
        m_ap  = m_pf[k] && (!m_on[k] || m_bnd || (sync && !m_stop[k]));
        if (!m_on[k]) begin
          if (m_en) begin m_on[k] = 1; m_stop[k] = 0; m_pos[k] = 0; end
        end else if (sync && !m_stop[k]) begin
          m_pos[k] = 0; m_stop[k] = !m_en;
        end else if (m_bnd) begin
          m_pos[k] = 0; m_on[k] = m_en; m_stop[k] = 0;
        end else begin
          m_pos[k] = m_pos[k] + 1; m_stop[k] = !m_en;
        end
        if (m_ap) m_d[k] = (m_pv[k] < 2) ? 2 : m_pv[k];
        if (div_wr[k]) begin
          m_pv[k] = int'(div_in[k*16 +: 16]); m_pf[k] = 1;
        end else if (m_ap) begin
          m_pf[k] = 0;
        end
      end
      e_clk[k]  = m_on[k] && (m_pos[k] < (m_d[k] + 1) / 2);
      e_tick[k] = m_on[k] && (m_pos[k] == 0);
      e_pend[k] = m_pf[k];
    end
  end

  task automatic wait_pos(input int k, input int p);
    for (int i = 0; i < 64; i++) begin
      if (m_on[k] && m_pos[k] == p) return;
      @(negedge clk);
    end
    n_chk++; n_fail++;
    $display("FAIL wait_pos ch%0d pos=%0d required %0d (timeout)", k, m_pos[k], p);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      if (!m_on[0] && !m_on[1]) return;
      @(negedge clk);
    end
    n_chk++; n_fail++;
    $display("FAIL wait_idle channels still running (timeout)");
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_en = 2'b11; div_wr = 2'b11; div_in = $urandom; sync = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({clk_div_o, tick_o, div_pending_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs got %b required 000000", {clk_div_o, tick_o, div_pending_o});
    end
    ch_en = 2'b00; div_wr = 2'b00; sync = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({clk_div_o, tick_o, div_pending_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_idle got %b required 000000", {clk_div_o, tick_o, div_pending_o});
    end
  endtask

  task automatic test_default();
    logic [15:0] cc = '0, ct = '0;
    ch_en = 2'b01;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_chk++;
      if ({clk_div_o, tick_o, div_pending_o} !== {e_clk, e_tick, e_pend}) begin
        n_fail++; $display("FAIL default_model t=%0t got %b %b %b required %b %b %b", $time, clk_div_o, tick_o, div_pending_o, e_clk, e_tick, e_pend);
      end
      cc = {cc[14:0], clk_div_o[0]}; ct = {ct[14:0], tick_o[0]};
    end
    n_chk++;
    if (cc[11:0] !== 12'b111000111000) begin n_fail++; $display("FAIL default_clk got %b required 111000111000", cc[11:0]); end
    n_chk++;
    if (ct[11:0] !== 12'b100000100000) begin n_fail++; $display("FAIL default_tick got %b required 100000100000", ct[11:0]); end
    ch_en = 2'b00;
    wait_idle();
  endtask

  task automatic test_div_load();
    logic [15:0] cc = '0, ct = '0;
    div_in[15:0] = 16'd5; div_wr = 2'b01;
    @(negedge clk);
    div_wr = 2'b00;
    n_chk++;
    if (div_pending_o[0] !== 1'b1) begin n_fail++; $display("FAIL idle_pend_set got %b required 1", div_pending_o[0]); end
    @(negedge clk);
    n_chk++;
    if (div_pending_o[0] !== 1'b0) begin n_fail++; $display("FAIL idle_pend_clr got %b required 0", div_pending_o[0]); end
    ch_en = 2'b01;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++;
      if ({clk_div_o, tick_o, div_pending_o} !== {e_clk, e_tick, e_pend}) begin
        n_fail++; $display("FAIL div5_model t=%0t got %b %b %b required %b %b %b", $time, clk_div_o, tick_o, div_pending_o, e_clk, e_tick, e_pend);
      end
      cc = {cc[14:0], clk_div_o[0]}; ct = {ct[14:0], tick_o[0]};
    end
    n_chk++;
    if (cc[9:0] !== 10'b1110011100) begin n_fail++; $display("FAIL div5_clk got %b required 1110011100", cc[9:0]); end
    n_chk++;
    if (ct[9:0] !== 10'b1000010000) begin n_fail++; $display("FAIL div5_tick got %b required 1000010000", ct[9:0]); end
    ch_en = 2'b00;
    wait_idle();
    div_in[15:0] = 16'd0; div_wr = 2'b01;
    @(negedge clk);
    div_wr = 2'b00;
    @(negedge clk);
    ch_en = 2'b01;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 5) begin div_in[15:0] = 16'd1; div_wr = 2'b01; end
      else div_wr = 2'b00;
      n_chk++;
      if ({clk_div_o, tick_o} !== {e_clk, e_tick}) begin
        n_fail++; $display("FAIL clamp_model t=%0t got %b %b required %b %b", $time, clk_div_o, tick_o, e_clk, e_tick);
      end
      cc = {cc[14:0], clk_div_o[0]}; ct = {ct[14:0], tick_o[0]};
    end
    n_chk++;
    if (cc[11:0] !== 12'b101010101010) begin n_fail++; $display("FAIL clamp_clk got %b required 101010101010", cc[11:0]); end
    n_chk++;
    if (ct[11:0] !== 12'b101010101010) begin n_fail++; $display("FAIL clamp_tick got %b required 101010101010", ct[11:0]); end
    ch_en = 2'b00;
    wait_idle();
  endtask

  task automatic test_midrun_write();
    logic [15:0] cc = '0, cp = '0;
    div_in[15:0] = 16'd6; div_wr = 2'b01;
    @(negedge clk);
    div_wr = 2'b00;
    @(negedge clk);
    ch_en = 2'b01;
    @(negedge clk);
    wait_pos(0, 2);
    div_in[15:0] = 16'd4; div_wr = 2'b01;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      div_wr = 2'b00;
      n_chk++;
      if ({clk_div_o, tick_o, div_pending_o} !== {e_clk, e_tick, e_pend}) begin
        n_fail++; $display("FAIL midwr_model t=%0t got %b %b %b required %b %b %b", $time, clk_div_o, tick_o, div_pending_o, e_clk, e_tick, e_pend);
      end
      cc = {cc[14:0], clk_div_o[0]}; cp = {cp[14:0], div_pending_o[0]};
    end
    n_chk++;
    if (cc[10:0] !== 11'b00011001100) begin n_fail++; $display("FAIL midwr_clk got %b required 00011001100", cc[10:0]); end
    n_chk++;
    if (cp[10:0] !== 11'b11100000000) begin n_fail++; $display("FAIL midwr_pend got %b required 11100000000", cp[10:0]); end
    wait_pos(0, 3);
    div_in[15:0] = 16'd6; div_wr = 2'b01;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      div_wr = 2'b00;
      n_chk++;
      if ({clk_div_o, tick_o, div_pending_o} !== {e_clk, e_tick, e_pend}) begin
        n_fail++; $display("FAIL bndwr_model t=%0t got %b %b %b required %b %b %b", $time, clk_div_o, tick_o, div_pending_o, e_clk, e_tick, e_pend);
      end
      cc = {cc[14:0], clk_div_o[0]}; cp = {cp[14:0], div_pending_o[0]};
    end
    n_chk++;
    if (cc[9:0] !== 10'b1100111000) begin n_fail++; $display("FAIL bndwr_clk got %b required 1100111000", cc[9:0]); end
    n_chk++;
    if (cp[9:0] !== 10'b1111000000) begin n_fail++; $display("FAIL bndwr_pend got %b required 1111000000", cp[9:0]); end
  endtask

  task automatic test_stop();
    logic [15:0] cc = '0;
    wait_pos(0, 1);
    ch_en = 2'b00;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_chk++;
      if ({clk_div_o, tick_o} !== {e_clk, e_tick}) begin
        n_fail++; $display("FAIL stop_model t=%0t got %b %b required %b %b", $time, clk_div_o, tick_o, e_clk, e_tick);
      end
      cc = {cc[14:0], clk_div_o[0]};
    end
    n_chk++;
    if (cc[7:0] !== 8'b10000000) begin n_fail++; $display("FAIL stop_clk got %b required 10000000", cc[7:0]); end
    ch_en = 2'b01;
    @(negedge clk);
    wait_pos(0, 1);
    ch_en = 2'b00;
    @(negedge clk);
    wait_pos(0, 4);
    ch_en = 2'b01;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_chk++;
      if ({clk_div_o, tick_o} !== {e_clk, e_tick}) begin
        n_fail++; $display("FAIL resume_model t=%0t got %b %b required %b %b", $time, clk_div_o, tick_o, e_clk, e_tick);
      end
      cc = {cc[14:0], clk_div_o[0]};
    end
    n_chk++;
    if (cc[11:0] !== 12'b011100011100) begin n_fail++; $display("FAIL resume_clk got %b required 011100011100", cc[11:0]); end
    ch_en = 2'b00;
    wait_idle();
  endtask

  task automatic test_sync();
    logic [15:0] c0 = '0, c1 = '0, t0 = '0, t1 = '0;
    div_in = {16'd8, 16'd4}; div_wr = 2'b11;
    @(negedge clk);
    div_wr = 2'b00;
    @(negedge clk);
    ch_en = 2'b01;
    repeat (3) @(negedge clk);
    ch_en = 2'b11;
    repeat (5) @(negedge clk);
    sync = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      sync = 1'b0;
      n_chk++;
      if ({clk_div_o, tick_o} !== {e_clk, e_tick}) begin
        n_fail++; $display("FAIL sync_model t=%0t got %b %b required %b %b", $time, clk_div_o, tick_o, e_clk, e_tick);
      end
      c0 = {c0[14:0], clk_div_o[0]}; c1 = {c1[14:0], clk_div_o[1]};
      t0 = {t0[14:0], tick_o[0]};    t1 = {t1[14:0], tick_o[1]};
    end
    n_chk++;
    if ({c0[7:0], c1[7:0]} !== {8'b11001100, 8'b11110000}) begin
      n_fail++; $display("FAIL sync_clk got %b %b required 11001100 11110000", c0[7:0], c1[7:0]);
    end
    n_chk++;
    if ({t0[7:0], t1[7:0]} !== {8'b10001000, 8'b10000000}) begin
      n_fail++; $display("FAIL sync_tick got %b %b required 10001000 10000000", t0[7:0], t1[7:0]);
    end
    ch_en = 2'b00;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] cc = '0;
    div_in[15:0] = 16'd8; div_wr = 2'b01;
    @(negedge clk);
    div_wr = 2'b00;
    @(negedge clk);
    ch_en = 2'b01;
    @(negedge clk);
    wait_pos(0, 2);
    div_in[15:0] = 16'd3; div_wr = 2'b01;
    @(negedge clk);
    div_wr = 2'b00; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({clk_div_o, tick_o, div_pending_o} !== 6'b0) begin
      n_fail++; $display("FAIL midreset got %b required 000000", {clk_div_o, tick_o, div_pending_o});
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_chk++;
      if ({clk_div_o, tick_o, div_pending_o} !== {e_clk, e_tick, e_pend}) begin
        n_fail++; $display("FAIL postreset_model t=%0t got %b %b %b required %b %b %b", $time, clk_div_o, tick_o, div_pending_o, e_clk, e_tick, e_pend);
      end
      cc = {cc[14:0], clk_div_o[0]};
    end
    n_chk++;
    if (cc[11:0] !== 12'b111000111000) begin n_fail++; $display("FAIL postreset_clk got %b required 111000111000", cc[11:0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      n_chk++;
      if ({clk_div_o, tick_o, div_pending_o} !== {e_clk, e_tick, e_pend}) begin
        n_fail++; $display("FAIL random_model cyc=%0d got %b %b %b required %b %b %b", c, clk_div_o, tick_o, div_pending_o, e_clk, e_tick, e_pend);
      end
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(7) == 0) ch_en[k] = ~ch_en[k];
        div_wr[k] = ($urandom_range(9) == 0);
        div_in[k*16 +: 16] = 16'($urandom_range(12));
      end
      sync = ($urandom_range(29) == 0);
      rst  = ($urandom_range(199) == 0);
    end
    rst = 1'b0; sync = 1'b0; div_wr = 2'b00; ch_en = 2'b00;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; ch_en = 2'b00; div_in = '0; div_wr = 2'b00; sync = 1'b0;
    test_reset();
    test_default();
    test_div_load();
    test_midrun_write();
    test_stop();
    test_sync();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
